stream_merge_weighted: RTL and testbench
========================================

// Module: stream_merge_weighted
// PURPOSE
//   N-to-1 stream merge. Arbitration is weighted round-robin.
//   Grants are packet-atomic: a port that wins keeps the output until its beat with last is accepted.
//   Successor to the plain round-robin/ordered merge, adding per-port packet weights and a registered, full-throughput output.
//   Sits ahead of a shared stream_split or a shared execution pipe; out_id carries the source port.
// PARAMETERS
//   PORTS        4   number of input streams (>=2)
//   DATA_WIDTH   32  payload width
//   WEIGHT_WIDTH 4   width of each per-port weight (packets per turn)
//   USE_LAST     1   1: packets delimited by in_last; 0: every beat is a packet
//   ID_WIDTH     $clog2(PORTS) (derived, min 1)  width of out_id
// PORTS
//   clk         in   1                     clock
//   rst         in   1                     reset, synchronous, active-high
//   in_valid    in   PORTS                 per-port valid
//   in_ready    out  PORTS                 per-port ready
//   in_payload  in   PORTS*DATA_WIDTH      per-port payload, port p at [p*DATA_WIDTH +: DATA_WIDTH]
//   in_last     in   PORTS                 per-port last flag (ignored if USE_LAST=0)
//   weight      in   PORTS*WEIGHT_WIDTH    packets port p may send per turn; 0 treated as 1
//   out_valid   out  1                     output valid (registered)
//   out_ready   in   1                     output ready
//   out_payload out  DATA_WIDTH            output payload (registered)
//   out_id      out  ID_WIDTH              source port of current beat (registered)
//   out_last    out  1                     last flag of current beat (registered; 1 when USE_LAST=0)
// BEHAVIOUR
//   Single clock domain. Reset is synchronous and active-high.
//   Reset state:
//     - out_valid=0, out_payload/out_id/out_last=0.
//     - State=IDLE, ptr=0, cur=0, credit=0.
//     - in_ready=0 for all ports while rst=1.
//   Output register:
//     - load = (!out_valid || out_ready).
//     - Accepted beat appears on out_* the next cycle; latency is 1 cycle.
//     - Sustains 1 beat/cycle when out_ready=1.
//   in_ready[p] = load && grant[p]. At most one in_ready bit is set per cycle.
//   A beat is accepted on port p when in_valid[p] && in_ready[p].
//   FSM IDLE:
//     - grant = first p with in_valid[p], searching circularly from ptr.
//     - The grant is combinational, so the first beat is accepted in the same cycle.
//     - On an accepted beat, cur<=p. If p!=cur or credit==0, credit<=max(weight[p],1); otherwise credit is kept.
//     - If the accepted beat is not last, go to LOCKED.
//   FSM LOCKED:
//     - grant = cur only. Other ports' valids are ignored.
//     - Stay in LOCKED until the beat with last is accepted from cur, then return to IDLE.
//   End of packet (accepted beat with last; every beat when USE_LAST=0):
//     - credit<=credit-1.
//     - If the new credit is 0: ptr<=(cur+1)%PORTS. Otherwise ptr<=cur, so cur keeps priority.
//   Weights are sampled only when a new turn starts. Changing weight mid-turn affects the next turn only.
//   No requester in IDLE: no grant, all in_ready=0, and ptr/credit are unchanged.
//   Idle owner with credit left: the circular search from ptr=cur falls through to the next requester, so there is no starvation.
//   A stalled output (out_ready=0, out_valid=1) drops all in_ready. State, credit and ptr hold.
//   Payload/last/id on a held output stay stable until accepted.
//   A source in LOCKED that deasserts valid keeps the lock; the arbiter waits with no timeout.
//   rst mid-packet aborts the lock and returns to the reset state. The partial packet is the sources' concern.
//   Single-beat packet (valid && last in IDLE): accepted, and the FSM stays in IDLE.
// TESTING
//   1. PORTS=4, all weights=1, ports 0-3 each send 3 single-beat packets, out_ready=1
//      -> out_id order 0,1,2,3,0,1,2,3,0,1,2,3; one beat/cycle after the first cycle.
//   2. weight0=3, weight1=1, ports 0 and 1 continuously valid with 1-beat packets
//      -> out_id pattern 0,0,0,1,0,0,0,1...
//   3. Port0 sends a 4-beat packet (0..3, last on 3), port1 is valid throughout
//      -> port1 is not granted until the beat with payload 3 is accepted; out_last=1 only on payload 3.
//   4. out_ready toggles randomly for 1024 beats on 2 ports
//      -> no beat is lost or duplicated, per-port order is preserved, out_* are stable while stalled.
//   5. Assert rst for one cycle mid-packet on port2
//      -> next cycle: out_valid=0, in_ready=0; after release, ptr=0 and port0 wins first.
//   6. USE_LAST=0, weight=0 on all ports
//      -> behaves as weight=1 round-robin; out_last=1 on every beat.

Source files
------------

// File: rtl/stream_merge_weighted.sv
// N-to-1 stream merge with packet-atomic weighted round-robin arbitration.
// Output stage is a single register that sustains one beat per cycle.
module stream_merge_weighted #(
    parameter int PORTS        = 4,
    parameter int DATA_WIDTH   = 32,
    parameter int WEIGHT_WIDTH = 4,
    parameter int USE_LAST     = 1,
    parameter int ID_WIDTH     = (PORTS > 1) ? $clog2(PORTS) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [PORTS-1:0]              in_valid,
    output logic [PORTS-1:0]              in_ready,
    input  logic [PORTS*DATA_WIDTH-1:0]   in_payload,
    input  logic [PORTS-1:0]              in_last,
    input  logic [PORTS*WEIGHT_WIDTH-1:0] weight,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DATA_WIDTH-1:0]         out_payload,
    output logic [ID_WIDTH-1:0]           out_id,
    output logic                          out_last
);
    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] LOCKED = 1'b1;

    logic [0:0]                             state;
    logic [ID_WIDTH-1:0]                    ptr, cur, gnt, gnt_inc;
    logic [WEIGHT_WIDTH-1:0]                credit, cred_base, cred_next, w_sel;
    logic [PORTS-1:0][DATA_WIDTH-1:0]       pay_arr;
    logic [PORTS-1:0][WEIGHT_WIDTH-1:0]     w_arr;
    logic                                   gnt_any, load, acc, beat_last;
    int                                     k;

    assign pay_arr = in_payload;
    assign w_arr   = weight;

    // Circular search from ptr; iterating backwards leaves the nearest requester as the winner.
    always_comb begin
        gnt     = cur;
        gnt_any = (state == LOCKED);
        k       = 0;
        if (state == IDLE) begin
            for (int i = PORTS - 1; i >= 0; i--) begin
                k = int'(ptr) + i;
                if (k >= PORTS) k = k - PORTS;
                if (in_valid[ID_WIDTH'(k)]) begin
                    gnt     = ID_WIDTH'(k);
                    gnt_any = 1'b1;
                end
            end
        end
    end

    assign load      = !out_valid || out_ready;
    assign acc       = !rst && load && gnt_any && in_valid[gnt];
    assign beat_last = (USE_LAST != 0) ? in_last[gnt] : 1'b1;
    assign w_sel     = w_arr[gnt];
    assign gnt_inc   = (gnt == ID_WIDTH'(PORTS - 1)) ? '0 : gnt + ID_WIDTH'(1);

    // A new turn (different port, or the owner ran out) reloads the weight; zero counts as one.
    assign cred_base = (state == IDLE && (gnt != cur || credit == '0))
                     ? ((w_sel == '0) ? WEIGHT_WIDTH'(1) : w_sel)
                     : credit;
    assign cred_next = cred_base - WEIGHT_WIDTH'(1);

    genvar p;
    generate
        for (p = 0; p < PORTS; p++) begin : g_rdy
            assign in_ready[p] = !rst && load && gnt_any && (gnt == ID_WIDTH'(p));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            ptr         <= '0;
            cur         <= '0;
            credit      <= '0;
            out_valid   <= 1'b0;
            out_payload <= '0;
            out_id      <= '0;
            out_last    <= 1'b0;
        end else begin
            if (load) begin
                out_valid <= acc;
                if (acc) begin
                    out_payload <= pay_arr[gnt];
                    out_id      <= gnt;
                    out_last    <= beat_last;
                end
            end
            if (acc) begin
                cur <= gnt;
                if (beat_last) begin
                    state  <= IDLE;
                    credit <= cred_next;
                    ptr    <= (cred_next == '0) ? gnt_inc : gnt;
                end else begin
                    state  <= LOCKED;
                    credit <= cred_base;
                end
            end
        end
    end
endmodule

// File: tb/tb_stream_merge_weighted.sv
// Directed + randomized bench for stream_merge_weighted; per-port scoreboard
// plus expected arbitration orders derived from the weighted round-robin rules.
module tb_stream_merge_weighted;
    localparam int P  = 4;
    localparam int DW = 32;
    localparam int WW = 4;
    localparam int IW = 2;

    logic           clk, rst;
    logic [P-1:0]   in_valid, in_ready, in_ready2, in_last;
    logic [P*DW-1:0] in_payload;
    logic [P*WW-1:0] weight;
    logic           out_ready;
    logic           out_valid, out_last, out_valid2, out_last2;
    logic [DW-1:0]  out_payload, out_payload2;
    logic [IW-1:0]  out_id, out_id2;

    stream_merge_weighted #(.PORTS(P), .DATA_WIDTH(DW), .WEIGHT_WIDTH(WW), .USE_LAST(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_payload(in_payload), .in_last(in_last), .weight(weight),
        .out_valid(out_valid), .out_ready(out_ready), .out_payload(out_payload),
        .out_id(out_id), .out_last(out_last));

    stream_merge_weighted #(.PORTS(P), .DATA_WIDTH(DW), .WEIGHT_WIDTH(WW), .USE_LAST(0)) dut_nl (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
        .in_payload(in_payload), .in_last(in_last), .weight(weight),
        .out_valid(out_valid2), .out_ready(out_ready), .out_payload(out_payload2),
        .out_id(out_id2), .out_last(out_last2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vecs = 0, errs = 0;
    logic [DW:0] srcq [P][$];   // {last, payload} waiting at each source
    logic [DW:0] expq [P][$];   // accepted by DUT, not yet seen on the output
    int          idq[$];
    logic [DW-1:0] payq[$];
    logic        lastq[$];
    int          nout, cyc, first_cyc, last_cyc, gap_pct, rdy_pct, lock_p;
    bit          lock_v, hold_v;
    logic [DW-1:0] hold_pay;
    logic [IW-1:0] hold_id;
    logic        hold_last;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic flush();
        for (int p = 0; p < P; p++) begin
            srcq[p].delete();
            expq[p].delete();
        end
        idq.delete(); payq.delete(); lastq.delete();
        nout = 0; first_cyc = -1; last_cyc = -1;
        lock_v = 0; hold_v = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; in_valid = '0; in_last = '0; out_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        flush();
    endtask

    task automatic push_pkt(input int p, input int len, input int seq0);
        for (int i = 0; i < len; i++)
            srcq[p].push_back({(i == len - 1) ? 1'b1 : 1'b0, 8'(p), 24'(seq0 + i)});
    endtask

    // One cycle: drive at negedge, sample just before the next posedge.
    task automatic step();
        logic [DW:0] e;
        @(negedge clk);
        for (int p = 0; p < P; p++) begin
            if (srcq[p].size() > 0 && $urandom_range(99) >= gap_pct) begin
                in_valid[p] = 1'b1;
                in_payload[p*DW +: DW] = srcq[p][0][DW-1:0];
                in_last[p] = srcq[p][0][DW];
            end else begin
                in_valid[p] = 1'b0;
                in_last[p]  = 1'b0;
            end
        end
        out_ready = ($urandom_range(99) < rdy_pct);
        #4;
        cyc++;
        chk("ready_onehot", ($countones(in_ready) <= 1), 1);
        if (hold_v) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_payload", out_payload, hold_pay);
            chk("hold_id", out_id, hold_id);
            chk("hold_last", out_last, hold_last);
        end
        if (out_valid && out_ready) begin
            idq.push_back(int'(out_id)); payq.push_back(out_payload); lastq.push_back(out_last);
            nout++;
            if (first_cyc < 0) first_cyc = cyc;
            last_cyc = cyc;
            if (lock_v) chk("packet_atomic", out_id, lock_p);
            lock_v = !out_last;
            lock_p = int'(out_id);
            chk("sb_expected", (expq[out_id].size() > 0), 1);
            if (expq[out_id].size() > 0) begin
                e = expq[out_id].pop_front();
                chk("sb_beat", {out_last, out_payload}, e);
            end
        end
        hold_v = out_valid && !out_ready;
        hold_pay = out_payload; hold_id = out_id; hold_last = out_last;
        for (int p = 0; p < P; p++)
            if (in_valid[p] && in_ready[p]) expq[p].push_back(srcq[p].pop_front());
    endtask

    task automatic wait_outs(input string tag, input int n, input int bound);
        int c = 0;
        while (nout < n && c < bound) begin step(); c++; end
        chk(tag, nout, n);
    endtask

    function automatic bit busy();
        busy = out_valid;
        for (int p = 0; p < P; p++) if (srcq[p].size() > 0 || expq[p].size() > 0) busy = 1;
    endfunction

    task automatic drain(input string tag, input int bound);
        int c = 0;
        while (busy() && c < bound) begin step(); c++; end
        chk(tag, busy(), 0);
    endtask

    initial begin
        int n, rem, len, seq;
        rst = 1'b1; in_valid = '0; in_last = '0; in_payload = '0; out_ready = 1'b1;
        weight = {P{4'd1}}; gap_pct = 0; rdy_pct = 100; cyc = 0;
        flush();

        // Reset state, with every source requesting.
        @(negedge clk);
        in_valid = '1; in_last = '1;
        #4;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_in_ready_nl", in_ready2, 0);
        @(negedge clk);
        #4;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_payload", out_payload, 0);
        chk("rst_out_id", out_id, 0);
        chk("rst_out_last", out_last, 0);
        do_reset();

        // Equal weights: plain rotation, back-to-back output.
        for (int p = 0; p < P; p++) for (int i = 0; i < 3; i++) push_pkt(p, 1, i);
        wait_outs("t1_count", 12, 100);
        for (int i = 0; i < 12 && i < idq.size(); i++) chk("t1_order", idq[i], i % 4);
        chk("t1_back_to_back", last_cyc - first_cyc, 11);
        drain("t1_drain", 50);

        // Port 0 weight 3, port 1 weight 1.
        do_reset();
        weight = {4'd1, 4'd1, 4'd1, 4'd3};
        for (int i = 0; i < 16; i++) begin push_pkt(0, 1, i); push_pkt(1, 1, i); end
        wait_outs("t2_count", 12, 100);
        for (int i = 0; i < 12 && i < idq.size(); i++) chk("t2_order", idq[i], (i % 4 == 3) ? 1 : 0);
        drain("t2_drain", 100);

        // Multi-beat packet holds the grant.
        do_reset();
        weight = {P{4'd1}};
        push_pkt(0, 4, 0);
        srcq[1].push_back({1'b1, 32'h100});
        wait_outs("t3_count", 5, 50);
        for (int i = 0; i < 5 && i < idq.size(); i++) begin
            chk("t3_id", idq[i], (i < 4) ? 0 : 1);
            chk("t3_payload", payq[i], (i < 4) ? i : 32'h100);
            chk("t3_last", lastq[i], (i >= 3) ? 1 : 0);
        end
        drain("t3_drain", 50);

        // Random backpressure and source gaps, 1024 beats over two ports.
        do_reset();
        weight = {4'd1, 4'd1, 4'($urandom_range(3)), 4'($urandom_range(3))};
        for (int p = 0; p < 2; p++) begin
            rem = 512; seq = 0;
            while (rem > 0) begin
                len = $urandom_range(1, 4);
                if (len > rem) len = rem;
                push_pkt(p, len, seq);
                seq += len; rem -= len;
            end
        end
        gap_pct = 25; rdy_pct = 50;
        drain("t4_drain", 20000);
        chk("t4_total", nout, 1024);
        gap_pct = 0; rdy_pct = 100;

        // Reset in the middle of a port-2 packet.
        do_reset();
        push_pkt(2, 4, 0);
        n = 0;
        while (srcq[2].size() > 2 && n < 50) begin step(); n++; end
        chk("t5_two_beats", srcq[2].size(), 2);
        @(negedge clk);
        rst = 1'b1;
        #4;
        chk("t5_rst_in_ready", in_ready, 0);
        @(negedge clk);
        rst = 1'b0; in_valid = '0;
        flush();
        #4;
        chk("t5_out_valid", out_valid, 0);
        chk("t5_in_ready", in_ready, 0);
        push_pkt(0, 1, 7);
        push_pkt(2, 1, 9);
        wait_outs("t5_count", 2, 50);
        if (idq.size() >= 2) begin
            chk("t5_first", idq[0], 0);
            chk("t5_second", idq[1], 2);
        end
        drain("t5_drain", 50);

        // USE_LAST=0 instance with zero weights: rotation, last on every beat.
        do_reset();
        weight = '0;
        @(negedge clk);
        in_valid = '1; in_last = '0; out_ready = 1'b1;
        for (int p = 0; p < P; p++) in_payload[p*DW +: DW] = 32'hA0 + p;
        n = 0;
        for (int c = 0; c < 40 && n < 12; c++) begin
            if (c > 0) @(negedge clk);
            #4;
            chk("t6_ready_onehot", ($countones(in_ready2) <= 1), 1);
            if (out_valid2) begin
                chk("t6_id", out_id2, n % 4);
                chk("t6_last", out_last2, 1);
                chk("t6_payload", out_payload2, 32'hA0 + (n % 4));
                n++;
            end
        end
        chk("t6_count", n, 12);
        do_reset();

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
